// File: rtl/syn_stage_rr_arbiter.sv
// Round-robin arbiter sharing one registered f/g stage (f = a & ~g, g = b | c) among N_REQ requesters.
// Mealy one-hot grant, result one cycle after grant, stalls grants while an unconsumed result is blocked.
module syn_stage_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_mask,
  input  logic [N_REQ-1:0] a_in,
  input  logic [N_REQ-1:0] b_in,
  input  logic [N_REQ-1:0] c_in,
  output logic [N_REQ-1:0] gnt,
  output logic             f,
  output logic             g,
  output logic             out_valid,
  output logic [ID_W-1:0]  out_id,
  input  logic             out_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  state_t           state_next;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  idx;
  logic [N_REQ-1:0] eligible;
  logic             can_issue;
  logic             issue;

  assign eligible  = req & req_mask;
  assign can_issue = (state == EMPTY) | out_ready;
  assign out_valid = (state == FULL);

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    issue = 1'b0;
    gnt   = '0;
    if (!reset && can_issue) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = ID_W'((int'(ptr) + k) % N_REQ);
        if (!issue && eligible[idx]) begin
          issue = 1'b1;
          win   = idx;
        end
      end
    end
    if (issue) begin
      gnt = N_REQ'(1) << win;
    end
  end

  always_comb begin
    state_next = state;
    if (issue) begin
      state_next = FULL;
    end else if (state == FULL && out_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // f uses the registered g from before this update: g is the shared feedback term.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f      <= 1'b0;
      g      <= 1'b0;
      out_id <= '0;
      ptr    <= ID_W'(N_REQ - 1);
    end else if (issue) begin
      f      <= a_in[win] & ~g;
      g      <= b_in[win] | c_in[win];
      out_id <= win;
      ptr    <= win;
    end
  end

endmodule

// File: tb/tb_syn_stage_rr_arbiter.sv
// Directed bench for syn_stage_rr_arbiter: reset, single issue, fairness, stall, g feedback, masking.
module tb_syn_stage_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req, req_mask, a_in, b_in, c_in;
  logic [3:0] gnt;
  logic       f, g, out_valid, out_ready;
  logic [1:0] out_id;

  int compared   = 0;
  int mismatched = 0;

  syn_stage_rr_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_mask(req_mask),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .gnt(gnt),
    .f(f), .g(g), .out_valid(out_valid), .out_id(out_id), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    #12;
    req = 4'b1111; req_mask = 4'b1111; out_ready = 1'b1;
    #1;
    compared++; if (gnt !== 4'b0000) begin mismatched++; $display("FAIL rst_gnt got=%b want=0000", gnt); end
    compared++; if ({f, g, out_valid} !== 3'b000) begin mismatched++; $display("FAIL rst_fgv got=%b want=000", {f, g, out_valid}); end
    compared++; if (out_id !== 2'd0) begin mismatched++; $display("FAIL rst_id got=%0d want=0", out_id); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single;
    req = 4'b0100; req_mask = 4'b1111; a_in = 4'b0100; b_in = 4'b0000; c_in = 4'b0100; out_ready = 1'b1;
    #1;
    compared++; if (gnt !== 4'b0100) begin mismatched++; $display("FAIL single_gnt got=%b want=0100", gnt); end
    @(posedge clk); #1;
    compared++; if ({f, g, out_valid} !== 3'b111) begin mismatched++; $display("FAIL single_fgv got=%b want=111", {f, g, out_valid}); end
    compared++; if (out_id !== 2'd2) begin mismatched++; $display("FAIL single_id got=%0d want=2", out_id); end
  endtask

  task automatic test_reset_mid_op;
    req = 4'b0000; out_ready = 1'b0;
    #2;
    reset = 1'b1; req = 4'b1111; req_mask = 4'b1111;
    #1;
    compared++; if (gnt !== 4'b0000) begin mismatched++; $display("FAIL midrst_gnt got=%b want=0000", gnt); end
    compared++; if ({f, g, out_valid} !== 3'b000) begin mismatched++; $display("FAIL midrst_fgv got=%b want=000", {f, g, out_valid}); end
    compared++; if (out_id !== 2'd0) begin mismatched++; $display("FAIL midrst_id got=%0d want=0", out_id); end
    #1;
    reset = 1'b0; out_ready = 1'b1; a_in = 4'b1111; b_in = 4'b1111; c_in = 4'b0000;
    #1;
    compared++; if (gnt !== 4'b0001) begin mismatched++; $display("FAIL midrst_first_gnt got=%b want=0001", gnt); end
  endtask

  task automatic test_fairness;
    logic [3:0] eg;
    for (int i = 0; i < 8; i++) begin
      eg = 4'b0001 << (i % 4);
      compared++; if (gnt !== eg) begin mismatched++; $display("FAIL fair_gnt[%0d] got=%b want=%b", i, gnt, eg); end
      @(posedge clk); #1;
      compared++; if (out_id !== 2'(i % 4)) begin mismatched++; $display("FAIL fair_id[%0d] got=%0d want=%0d", i, out_id, i % 4); end
      compared++; if ({f, g, out_valid} !== {(i == 0), 2'b11}) begin mismatched++; $display("FAIL fair_fgv[%0d] got=%b want=%b", i, {f, g, out_valid}, {(i == 0), 2'b11}); end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; req = 4'b0011; a_in = 4'b0011; b_in = 4'b0000; c_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++; if (gnt !== 4'b0000) begin mismatched++; $display("FAIL stall_gnt[%0d] got=%b want=0000", i, gnt); end
      @(posedge clk); #1;
      compared++; if ({f, g, out_valid, out_id} !== 5'b01111) begin mismatched++; $display("FAIL stall_hold[%0d] got=%b want=01111", i, {f, g, out_valid, out_id}); end
    end
    out_ready = 1'b1;
    #1;
    compared++; if (gnt !== 4'b0001) begin mismatched++; $display("FAIL stall_release_gnt got=%b want=0001", gnt); end
    @(posedge clk); #1;
    compared++; if ({f, g, out_valid, out_id} !== 5'b00100) begin mismatched++; $display("FAIL stall_release_res got=%b want=00100", {f, g, out_valid, out_id}); end
    req = 4'b0000;
    @(posedge clk); #1;
    compared++; if ({f, g, out_valid, out_id} !== 5'b00000) begin mismatched++; $display("FAIL drain got=%b want=00000", {f, g, out_valid, out_id}); end
  endtask

  task automatic test_g_feedback;
    a_in = 4'b0111; b_in = 4'b0001; c_in = 4'b0000; out_ready = 1'b1;
    req = 4'b0001;
    #1;
    compared++; if (gnt !== 4'b0001) begin mismatched++; $display("FAIL fb0_gnt got=%b want=0001", gnt); end
    @(posedge clk); #1;
    compared++; if ({f, g, out_id} !== 4'b1100) begin mismatched++; $display("FAIL fb0_res got=%b want=1100", {f, g, out_id}); end
    req = 4'b0010;
    @(posedge clk); #1;
    compared++; if ({f, g, out_id} !== 4'b0001) begin mismatched++; $display("FAIL fb1_res got=%b want=0001", {f, g, out_id}); end
    req = 4'b0100;
    @(posedge clk); #1;
    compared++; if ({f, g, out_valid, out_id} !== 5'b10110) begin mismatched++; $display("FAIL fb2_res got=%b want=10110", {f, g, out_valid, out_id}); end
  endtask

  task automatic test_masking;
    int order [6] = '{3, 0, 1, 3, 0, 1};
    logic [3:0] eg;
    // Move the pointer to 1 first (search from 2 wraps through 3, 0 to 1).
    req = 4'b0010;
    @(posedge clk); #1;
    compared++; if (out_id !== 2'd1) begin mismatched++; $display("FAIL mask_prep_id got=%0d want=1", out_id); end
    req = 4'b1111; req_mask = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      #1;
      eg = 4'b0001 << order[i];
      compared++; if (gnt !== eg) begin mismatched++; $display("FAIL mask_gnt[%0d] got=%b want=%b", i, gnt, eg); end
      @(posedge clk); #1;
      compared++; if (out_id !== 2'(order[i])) begin mismatched++; $display("FAIL mask_id[%0d] got=%0d want=%0d", i, out_id, order[i]); end
    end
    req_mask = 4'b0000;
    #1;
    compared++; if (gnt !== 4'b0000) begin mismatched++; $display("FAIL allmask_gnt got=%b want=0000", gnt); end
    @(posedge clk); #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL allmask_valid got=%b want=0", out_valid); end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_mask = '0; a_in = '0; b_in = '0; c_in = '0; out_ready = 1'b0;
    test_reset;
    test_single;
    test_reset_mid_op;
    test_fairness;
    test_backpressure;
    test_g_feedback;
    test_masking;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/syn_stage_rr_arbiter.md
Name: syn_stage_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered f/g compute stage between N_REQ requesters.
- The stage computes f_next = a & ~g and g_next = b | c. The g term is the stage's own registered g, shared across all requesters.
- The block grants at most one requester per cycle, performs the register update, and presents the result with valid/ready backpressure.
- It sits between independent requester logic and a single downstream consumer of f/g.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of out_id; must equal clog2(N_REQ).

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request; held until granted.
- req_mask  input  N_REQ  1 = requester enabled; a masked requester is never granted.
- a_in  input  N_REQ  per-requester a operand.
- b_in  input  N_REQ  per-requester b operand.
- c_in  input  N_REQ  per-requester c operand.
- gnt  output  N_REQ  one-hot grant, combinational (Mealy); a transfer occurs when req[i] & gnt[i].
- f  output  1  registered f result.
- g  output  1  registered g result; also the feedback term.
- out_valid  output  1  f/g/out_id hold an unconsumed result.
- out_id  output  ID_W  index of the requester that produced the current result.
- out_ready  input  1  downstream accepts the result when out_valid & out_ready.

Behaviour:
- Reset (async, immediate, independent of clk):
  - state=EMPTY; f=0, g=0, out_valid=0, out_id=0.
  - ptr=N_REQ-1, so requester 0 has first priority.
  - gnt forced to all-zero while reset is high.
- Definitions:
  - eligible = req & req_mask.
  - can_issue = (state==EMPTY) | out_ready.
- Arbitration (combinational, same cycle):
  - If can_issue and eligible != 0, the winner w is the first eligible index searching ptr+1, ptr+2, … with mod N_REQ wrap.
  - gnt = one-hot(w) in that case; otherwise gnt = 0.
  - gnt is never asserted to a requester that has req low or mask low.
- Issue (posedge ending a cycle with gnt != 0):
  - f <= a_in[w] & ~g, using g's current registered value.
  - g <= b_in[w] | c_in[w].
  - out_id <= w; ptr <= w; state <= FULL; out_valid <= 1.
  - Latency: grant in cycle t, result visible in cycle t+1.
- FSM:
  - EMPTY --issue--> FULL.
  - FULL & out_ready & issue --> FULL with new result. Back-to-back issue gives one result per cycle.
  - FULL & out_ready & no issue --> EMPTY; out_valid <= 0; f/g/out_id retain their values.
  - FULL & !out_ready --> FULL (stall). gnt=0; f, g, out_id, ptr are stable; no operand sampled.
- ptr changes only on issue. Masked or idle requesters never advance the pointer.
- Consuming and issuing in the same cycle is legal and loses no result.
- Changing req_mask mid-stream affects only the arbitration in the same cycle. An already-registered result is unaffected.
- A requester that drops req before being granted is simply skipped; no error is raised.
- out_id values >= N_REQ never occur.
- Reset asserted mid-stall or mid-issue discards the pending result; no partial update is permitted.

Test Plan:
1. Reset mid-operation: with out_valid=1, f=1, g=1, assert reset between clock edges -> f=0, g=0, out_valid=0, gnt=0 immediately. After release, the first grant with all requesting goes to requester 0.
2. Single request: g=0, req=0100, mask=1111, a_in[2]=1, b_in[2]=0, c_in[2]=1, out_ready=1 -> gnt=0100 in the same cycle. Next cycle: f=1, g=1, out_id=2, out_valid=1.
3. Fairness: req=1111 held, mask=1111, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3, out_valid continuously 1.
4. Backpressure: out_valid=1, out_ready=0 for 3 cycles, req=0011 -> gnt=0000 and f/g/out_id unchanged for all 3 cycles. When out_ready=1, gnt asserts in that cycle and the new result appears the next cycle.
5. g feedback: issue requester 0 (a=1, b=1, c=0) and result g=1, then requester 1 (a=1, b=0, c=0) -> second result f=0, g=0. Issue requester 2 (a=1) next -> f=1.
6. Masking/skip: req=1111, mask=1011, ptr=1 -> grant order 3,0,1,3,0,1; requester 2 is never granted, and ptr never equals 2.
